display_score_scan: RTL and testbench

- Parametrised successor to the single-width score display; drives a DIGITS-wide multiplexed 7-segment bank from a SCORE_W-bit binary score.
- A sequential double-dabble converter turns the score into BCD (re-run only when the score changes). A scan FSM time-multiplexes the digits, with leading-zero blanking, overflow saturation and optional blink.
- Sits between game score logic and the board's segment/anode pins.

---
 rtl/display_score_scan_if.sv | 22 ++
 rtl/display_score_scan.sv | 197 +++++++++++++++++++
 tb/tb_display_score_scan.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_score_scan_if.sv
// Score display bus: the game-side score and blink request going in, and
// the segment, anode and busy pins coming back out.
interface display_score_scan_if #(
    parameter int SCORE_W = 10,
    parameter int DIGITS  = 4
);
    logic [SCORE_W-1:0] i_score;
    logic               i_blink_en;
    logic [7:0]         o_segment;
    logic [DIGITS-1:0]  o_segment_an;
    logic               o_busy;

    modport master (
        output i_score, i_blink_en,
        input  o_segment, o_segment_an, o_busy
    );

    modport slave (
        input  i_score, i_blink_en,
        output o_segment, o_segment_an, o_busy
    );
endinterface

// File: rtl/display_score_scan.sv
// Multiplexed 7-segment score display. A sequential double-dabble converter
// turns the binary score into BCD whenever the score changes. The result is
// copied into a display register in one step, so the scanner never shows a
// digit that mixes the old and new scores. The scanner walks the digits one
// at a time and applies leading-zero blanking, an overflow dp flag and an
// optional whole-display blink.
module display_score_scan #(
    parameter int SCORE_W     = 10,
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 256,
    parameter int BLANK_LZ    = 1
) (
    input  logic clk,
    input  logic rst,
    display_score_scan_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    conv_state_t        state;
    logic [SCORE_W-1:0] last_score;
    logic [SCORE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_sr;
    logic [CNT_W-1:0]   shift_cnt;
    logic               busy;
    logic [BCD_W-1:0]   disp_bcd;
    logic               disp_ovf;

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [IDX_W-1:0]   scan_idx;
    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_on;

    logic [DIGITS-1:0]  keep;
    logic               nz_seen;
    logic [3:0]         cur_digit;
    logic [7:0]         seg_next;
    logic [DIGITS-1:0]  an_next;
    logic [7:0]         seg_q;
    logic [DIGITS-1:0]  an_q;

    // Active-low g..a pattern for one BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Double-dabble add-3 step: any BCD digit of 5 or more is bumped by 3
    // so that the following left shift carries into the next digit.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
        end
    end

    // Converter FSM. A bit carried out of the top digit means the score
    // needs more digits than the bank has, so it is folded into a sticky
    // overflow flag rather than being dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_score <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            ovf_sr     <= 1'b0;
            shift_cnt  <= '0;
            busy       <= 1'b0;
            disp_bcd   <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_score != last_score) begin
                        last_score <= bus.i_score;
                        bin_sr     <= bus.i_score;
                        bcd_sr     <= '0;
                        ovf_sr     <= 1'b0;
                        shift_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    ovf_sr <= ovf_sr | bcd_adj[BCD_W-1];
                    bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
                    bin_sr <= bin_sr << 1;
                    if (shift_cnt == CNT_W'(SCORE_W - 1))
                        state <= LOAD;
                    else
                        shift_cnt <= shift_cnt + 1'b1;
                end
                LOAD: begin
                    if (ovf_sr) begin
                        disp_bcd <= {DIGITS{4'h9}};
                        disp_ovf <= 1'b1;
                    end else begin
                        disp_bcd <= bcd_sr;
                        disp_ovf <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Scan timebase: the divider makes a tick, ticks step the digit index
    // and the blink counter, which toggles the blink phase when it wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            scan_idx  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick) begin
            div_cnt <= '0;
            if (scan_idx == IDX_W'(DIGITS - 1))
                scan_idx <= '0;
            else
                scan_idx <= scan_idx + 1'b1;
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Leading-zero mask: walk down from the top digit. A digit is kept once
    // any digit at or above it is non-zero. Digit 0 is always kept.
    always_comb begin
        keep    = '0;
        nz_seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_seen = nz_seen | (disp_bcd[4*k +: 4] != 4'd0);
            keep[k] = nz_seen | (k == 0) | (BLANK_LZ == 0);
        end
    end

    assign cur_digit = disp_bcd[{scan_idx, 2'b00} +: 4];

    // Segment and anode pattern for the digit under the scan index.
    always_comb begin
        seg_next = 8'hFF;
        an_next  = '1;
        if (!(bus.i_blink_en && !blink_on)) begin
            an_next[scan_idx] = 1'b0;
            if (keep[scan_idx])
                seg_next[6:0] = seg7(cur_digit);
            if ((scan_idx == '0) && disp_ovf)
                seg_next[7] = 1'b0;
        end
    end

    // Pin registers, so the segment and anode pins change together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
        end
    end

    assign bus.o_segment    = seg_q;
    assign bus.o_segment_an = an_q;
    assign bus.o_busy       = busy;
endmodule

// File: tb/tb_display_score_scan.sv
// Directed bench for display_score_scan. A 4-digit and a 3-digit instance
// are driven with the same scores. Each task checks one behaviour, using
// expected values worked out by hand from the decode table.
module tb_display_score_scan;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] seen4 [4];
    logic [7:0] seen3 [3];

    display_score_scan_if #(.SCORE_W(10), .DIGITS(4)) bus4 ();
    display_score_scan_if #(.SCORE_W(10), .DIGITS(3)) bus3 ();

    display_score_scan #(
        .SCORE_W(10), .DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(2), .BLANK_LZ(1)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    display_score_scan #(
        .SCORE_W(10), .DIGITS(3), .SCAN_DIV(4), .BLINK_TICKS(2), .BLANK_LZ(1)
    ) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_score(input logic [9:0] v);
        bus4.i_score = v;
        bus3.i_score = v;
    endtask

    task automatic set_blink(input logic v);
        bus4.i_blink_en = v;
        bus3.i_blink_en = v;
    endtask

    // Records the segment pattern shown for each digit over one full scan.
    task automatic capture();
        logic [3:0] p4;
        logic [2:0] p3;
        for (int k = 0; k < 4; k++) seen4[k] = 8'hxx;
        for (int k = 0; k < 3; k++) seen3[k] = 8'hxx;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                p4 = ~(4'b0001 << k);
                if (bus4.o_segment_an === p4) seen4[k] = bus4.o_segment;
            end
            for (int k = 0; k < 3; k++) begin
                p3 = ~(3'b001 << k);
                if (bus3.o_segment_an === p3) seen3[k] = bus3.o_segment;
            end
        end
    endtask

    // Waits, with a bound, until both converters are idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus4.o_busy !== 1'b0 || bus3.o_busy !== 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus4.o_busy !== 1'b0 || bus3.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout busy4=%b busy3=%b expected 0", bus4.o_busy, bus3.o_busy);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        rst = 1'b0;
        set_score(10'd0);
        set_blink(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.o_segment !== 8'hFF || bus4.o_segment_an !== 4'b1111 || bus4.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state4 got seg=%h an=%b busy=%b expected FF 1111 0",
                     bus4.o_segment, bus4.o_segment_an, bus4.o_busy);
        end
        checks++;
        if (bus3.o_segment !== 8'hFF || bus3.o_segment_an !== 3'b111 || bus3.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state3 got seg=%h an=%b busy=%b expected FF 111 0",
                     bus3.o_segment, bus3.o_segment_an, bus3.o_busy);
        end
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_an  = ~(4'b0001 << (c / 4));
            exp_seg = (c < 4) ? 8'hC0 : 8'hFF;
            checks++;
            if (bus4.o_segment_an !== exp_an || bus4.o_segment !== exp_seg) begin
                errors++;
                $display("[TB] FAIL scan_seq[%0d] got an=%b seg=%h expected an=%b seg=%h",
                         c, bus4.o_segment_an, bus4.o_segment, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_score_12();
        int hi;
        int n;
        set_score(10'd12);
        @(negedge clk);
        checks++;
        if (bus4.o_busy !== 1'b1 || bus3.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_start got %b/%b expected 1/1", bus4.o_busy, bus3.o_busy);
        end
        hi = 1;
        n  = 0;
        while (bus4.o_busy === 1'b1 && n < 40) begin
            @(negedge clk);
            if (bus4.o_busy === 1'b1) hi++;
            n++;
        end
        checks++;
        if (hi != 11) begin
            errors++;
            $display("[TB] FAIL busy_len got %0d cycles expected 11", hi);
        end
        capture();
        checks++;
        if (seen4[0] !== 8'hA4 || seen4[1] !== 8'hF9 || seen4[2] !== 8'hFF || seen4[3] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL digits4_12 got %h %h %h %h expected A4 F9 FF FF",
                     seen4[0], seen4[1], seen4[2], seen4[3]);
        end
        checks++;
        if (seen3[0] !== 8'hA4 || seen3[1] !== 8'hF9 || seen3[2] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL digits3_12 got %h %h %h expected A4 F9 FF",
                     seen3[0], seen3[1], seen3[2]);
        end
    endtask

    task automatic test_overflow();
        set_score(10'd1023);
        repeat (2) @(negedge clk);
        wait_idle();
        capture();
        checks++;
        if (seen3[0] !== 8'h10 || seen3[1] !== 8'h90 || seen3[2] !== 8'h90) begin
            errors++;
            $display("[TB] FAIL overflow3 got %h %h %h expected 10 90 90",
                     seen3[0], seen3[1], seen3[2]);
        end
        checks++;
        if (seen4[0] !== 8'hB0 || seen4[1] !== 8'hA4 || seen4[2] !== 8'hC0 || seen4[3] !== 8'hF9) begin
            errors++;
            $display("[TB] FAIL fit4_1023 got %h %h %h %h expected B0 A4 C0 F9",
                     seen4[0], seen4[1], seen4[2], seen4[3]);
        end
    endtask

    task automatic test_back_to_back();
        int   rises;
        int   hi;
        logic prev;
        logic saw2;
        rises = 0;
        hi    = 0;
        prev  = 1'b0;
        saw2  = 1'b0;
        set_score(10'd2);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus4.o_busy === 1'b1) hi++;
            if (bus4.o_busy === 1'b1 && !prev) rises++;
            prev = bus4.o_busy;
            if (bus4.o_segment_an === 4'b1110) begin
                checks++;
                if (bus4.o_segment !== 8'hB0 && bus4.o_segment !== 8'hA4 && bus4.o_segment !== 8'h92) begin
                    errors++;
                    $display("[TB] FAIL b2b_digit0_4 got %h expected B0/A4/92", bus4.o_segment);
                end
            end
            if (bus3.o_segment_an === 3'b110) begin
                checks++;
                if (bus3.o_segment !== 8'h10 && bus3.o_segment !== 8'hA4 && bus3.o_segment !== 8'h92) begin
                    errors++;
                    $display("[TB] FAIL b2b_digit0_3 got %h expected 10/A4/92", bus3.o_segment);
                end
                if (bus3.o_segment === 8'hA4) saw2 = 1'b1;
            end
            if (c == 3) set_score(10'd5);
        end
        checks++;
        if (rises != 2 || hi != 22) begin
            errors++;
            $display("[TB] FAIL b2b_busy got rises=%0d high=%0d expected rises=2 high=22", rises, hi);
        end
        checks++;
        if (saw2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_shows_2 got seen=%b expected 1", saw2);
        end
        capture();
        checks++;
        if (seen4[0] !== 8'h92 || seen4[1] !== 8'hFF || seen4[2] !== 8'hFF || seen4[3] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL b2b_final4 got %h %h %h %h expected 92 FF FF FF",
                     seen4[0], seen4[1], seen4[2], seen4[3]);
        end
        checks++;
        if (seen3[0] !== 8'h92 || seen3[1] !== 8'hFF || seen3[2] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL b2b_final3 got %h %h %h expected 92 FF FF",
                     seen3[0], seen3[1], seen3[2]);
        end
    endtask

    task automatic test_blink();
        int   n;
        int   len;
        logic seen_lit;
        logic found;
        set_blink(1'b1);
        seen_lit = 1'b0;
        found    = 1'b0;
        n        = 0;
        while (!found && n < 64) begin
            @(negedge clk);
            if (bus4.o_segment_an !== 4'b1111) seen_lit = 1'b1;
            else if (seen_lit) found = 1'b1;
            n++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL blink_start got no dark phase expected one within 64 cycles");
        end
        for (int run = 0; run < 3; run++) begin
            len = 1;
            n   = 0;
            while (n < 40) begin
                @(negedge clk);
                n++;
                if ((bus4.o_segment_an === 4'b1111) == (run != 1)) len++;
                else break;
            end
            checks++;
            if (len != 8) begin
                errors++;
                $display("[TB] FAIL blink_run[%0d] got %0d cycles expected 8", run, len);
            end
        end
        n = 0;
        while (bus4.o_segment_an !== 4'b1111 && n < 20) begin
            @(negedge clk);
            n++;
        end
        set_blink(1'b0);
        @(negedge clk);
        checks++;
        if (bus4.o_segment_an === 4'b1111) begin
            errors++;
            $display("[TB] FAIL blink_clear got an=%b expected a lit digit", bus4.o_segment_an);
        end
    endtask

    task automatic test_reset_mid_shift();
        set_score(10'd300);
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midshift_busy got %b expected 1", bus4.o_busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus4.o_segment !== 8'hFF || bus4.o_segment_an !== 4'b1111 || bus4.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got seg=%h an=%b busy=%b expected FF 1111 0",
                     bus4.o_segment, bus4.o_segment_an, bus4.o_busy);
        end
        set_score(10'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus4.o_busy !== 1'b0 || bus3.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_busy got %b/%b expected 0/0", bus4.o_busy, bus3.o_busy);
        end
        capture();
        checks++;
        if (seen4[0] !== 8'hC0 || seen4[1] !== 8'hFF || seen4[2] !== 8'hFF || seen4[3] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL post_reset4 got %h %h %h %h expected C0 FF FF FF",
                     seen4[0], seen4[1], seen4[2], seen4[3]);
        end
        checks++;
        if (seen3[0] !== 8'hC0 || seen3[1] !== 8'hFF || seen3[2] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL post_reset3 got %h %h %h expected C0 FF FF",
                     seen3[0], seen3[1], seen3[2]);
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        set_score(10'd0);
        set_blink(1'b0);
        $display("[TB] display_score_scan bench starting");
        test_reset();
        test_score_12();
        test_overflow();
        test_back_to_back();
        test_blink();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
